bullet_fire_arbiter: RTL and testbench
======================================

// Module: bullet_fire_arbiter
// PURPOSE
//  Shares the single bullet engine among NUM_REQ tank controllers (player + AI tanks).
//  Latches 1-cycle fire requests with each tank's orientation and grants the engine round-robin.
//  Issues a launch pulse, tracks the bullet in flight, then enforces a cooldown.
//  Sits between the tank movement/fire FSMs and the bullet datapath.
// PARAMETERS
//  NUM_REQ      4         requester count, legal 2..8; OWN_W = $clog2(NUM_REQ) (localparam)
//  COOLDOWN_CNT 12000000  idle cycles after a bullet ends before the next grant
//  ACK_TIMEOUT  16        cycles to wait for bullet_act after launch before abandoning
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-low reset
//  enable        in   1          game running; low = pause
//  fire_req      in   NUM_REQ    per-tank fire pulse (bit i = tank i)
//  orient_in     in   2*NUM_REQ  tank i orientation at [2i+1:2i]; UP=00 DOWN=01 LEFT=10 RIGHT=11
//  bullet_act    in   1          bullet engine busy (bullet on screen)
//  launch        out  1          1-cycle pulse: start bullet
//  launch_orient out  2          direction for the launched bullet
//  owner         out  OWN_W      index of the tank that owns the current/last bullet
//  owner_valid   out  1          high from launch until the bullet ends or the launch times out
//  grant         out  NUM_REQ    one-hot 1-cycle pulse, coincident with launch
//  pending       out  NUM_REQ    latched, not-yet-served requests
//  busy          out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; launch=0; grant=0; launch_orient=00; owner=0;
//   owner_valid=0; pending=0; counters=0; rr_last=NUM_REQ-1, so tank 0 has first priority.
//  Request latch (every state): fire_req[i]=1 -> pending[i]<=1 and orient_lat[i]<=orient_in[i].
//   A repeat request while pending refreshes orient_lat only (no queueing; one outstanding per tank).
//  FSM states: IDLE, LAUNCH, FLIGHT, COOLDOWN.
//  IDLE: enable && |pending -> winner w = first set pending bit searching rr_last+1, +2, ... mod NUM_REQ.
//   Same edge: launch<=1, grant<=1<<w, launch_orient<=orient_lat[w], owner<=w,
//   owner_valid<=1, pending[w]<=0, rr_last<=w, go LAUNCH.
//   Grant latency: 1 cycle from the pending bit being visible in IDLE.
//  Request and grant of the same tank on the same edge: pending[w] stays 1, and orient_lat takes the new orient_in.
//  LAUNCH: launch/grant deassert after 1 cycle.
//   bullet_act==1 -> FLIGHT.
//   Otherwise the timeout counter increments; at ACK_TIMEOUT -> owner_valid<=0, go COOLDOWN.
//  FLIGHT: bullet_act==0 -> owner_valid<=0, cooldown counter cleared, go COOLDOWN.
//  COOLDOWN: counter increments; at COOLDOWN_CNT-1 -> IDLE. COOLDOWN_CNT=0 -> straight to IDLE next cycle.
//  enable==0: blocks new grants and freezes the timeout and cooldown counters.
//   Request latching and FLIGHT exit still operate (the bullet engine owns bullet_act).
//  owner holds its last value after owner_valid drops; consumers qualify it with owner_valid.
//  Reset mid-flight: immediate return to reset values; the bullet engine is not notified.
//  Counters are sized to hold COOLDOWN_CNT and ACK_TIMEOUT without wrap.
// CONFIGURATION
//  FIRE_ARB_PLAYER_PRIO_EN defined: tank 0 (player) wins whenever pending[0]=1.
//   Remaining tanks use round-robin among 1..NUM_REQ-1; rr_last is updated only by AI grants.
//  Not defined: pure round-robin over all NUM_REQ tanks as described above.
// TESTING (bench: NUM_REQ=4, COOLDOWN_CNT=8, ACK_TIMEOUT=4; bullet model raises bullet_act 2 cycles after launch and holds it 10 cycles)
//  1. Single fire: fire_req=0001, orient_in[1:0]=11 -> next cycle launch=1, grant=0001, launch_orient=11,
//     owner=0; owner_valid low 1 cycle after bullet_act falls; busy low 8 cycles later.
//  2. Round-robin: fire_req=1111 in one cycle -> grants in order 0001,0010,0100,1000,
//     each separated by flight + 8-cycle cooldown.
//  3. Timeout: bullet model never raises bullet_act -> owner_valid falls 4 cycles after launch,
//     then 8 cooldown cycles, then IDLE.
//  4. Pause: enable=0 during COOLDOWN with pending=0100 -> no grant and counter frozen;
//     enable=1 -> grant after the remaining cooldown.
//  5. Async reset asserted in FLIGHT -> all outputs at reset values without a clock edge; pending=0.
//  6. Macro on: pending=1110 then fire_req=0001 during cooldown -> next grant 0001;
//     the following grant resumes AI round-robin.

Source files
------------

// File: rtl/bullet_fire_arbiter_if.sv
// Handshake bundle between the tank fire FSMs, the bullet arbiter and the bullet engine.
// master = requester/engine side, slave = arbiter side.
interface bullet_fire_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                   enable;
    logic [NUM_REQ-1:0]     fire_req;
    logic [2*NUM_REQ-1:0]   orient_in;
    logic                   bullet_act;
    logic                   launch;
    logic [1:0]             launch_orient;
    logic [OWN_W-1:0]       owner;
    logic                   owner_valid;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     pending;
    logic                   busy;

    modport master (
        output enable, fire_req, orient_in, bullet_act,
        input  launch, launch_orient, owner, owner_valid,
        input  grant, pending, busy
    );

    modport slave (
        input  enable, fire_req, orient_in, bullet_act,
        output launch, launch_orient, owner, owner_valid,
        output grant, pending, busy
    );
endinterface

// File: rtl/bullet_fire_arbiter.sv
// Round-robin arbiter sharing one bullet engine among NUM_REQ tanks.
// Define FIRE_ARB_PLAYER_PRIO_EN to give tank 0 (player) absolute priority.
module bullet_fire_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int COOLDOWN_CNT = 12000000,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bullet_fire_arbiter_if.slave  bus
);
    localparam int OWN_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (COOLDOWN_CNT > ACK_TIMEOUT) ? COOLDOWN_CNT : ACK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CD_LAST =
        CNT_W'((COOLDOWN_CNT > 0) ? COOLDOWN_CNT - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        FLIGHT   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_REQ-1:0]        pending_q, pending_d;
    logic [NUM_REQ-1:0][1:0]   orient_lat_q, orient_lat_d;
    logic [OWN_W-1:0]          rr_last_q, rr_last_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      launch_q, launch_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [1:0]                lorient_q, lorient_d;
    logic [OWN_W-1:0]          owner_q, owner_d;
    logic                      ov_q, ov_d;

    logic                      win_found;
    logic [OWN_W-1:0]          win_idx;
    logic [OWN_W-1:0]          cand;
    logic [NUM_REQ-1:0]        pend_clr;

    // First pending bit after rr_last, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef FIRE_ARB_PLAYER_PRIO_EN
        if (pending_q[0]) begin
            win_found = 1'b1;
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = OWN_W'((int'(rr_last_q) + k) % NUM_REQ);
            if (!win_found && cand != '0 && pending_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = OWN_W'((int'(rr_last_q) + k) % NUM_REQ);
            if (!win_found && pending_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        launch_d  = 1'b0;
        grant_d   = '0;
        lorient_d = lorient_q;
        owner_d   = owner_q;
        ov_d      = ov_q;
        pend_clr  = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.enable && win_found) begin
                    launch_d  = 1'b1;
                    grant_d   = NUM_REQ'(1) << win_idx;
                    pend_clr  = NUM_REQ'(1) << win_idx;
                    lorient_d = orient_lat_q[win_idx];
                    owner_d   = win_idx;
                    ov_d      = 1'b1;
                    cnt_d     = '0;
                    state_d   = LAUNCH;
`ifdef FIRE_ARB_PLAYER_PRIO_EN
                    if (win_idx != '0) begin
                        rr_last_d = win_idx;
                    end
`else
                    rr_last_d = win_idx;
`endif
                end
            end
            LAUNCH: begin
                if (bus.bullet_act) begin
                    cnt_d   = '0;
                    state_d = FLIGHT;
                end else if (bus.enable) begin
                    if (cnt_q == TO_LAST) begin
                        ov_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = COOLDOWN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLIGHT: begin
                if (!bus.bullet_act) begin
                    ov_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (bus.enable) begin
                    if (cnt_q == CD_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request landing on its own grant edge re-arms the pending bit
    always_comb begin
        pending_d    = (pending_q & ~pend_clr) | bus.fire_req;
        orient_lat_d = orient_lat_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.fire_req[i]) begin
                orient_lat_d[i] = bus.orient_in[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            orient_lat_q <= '0;
            rr_last_q    <= OWN_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            launch_q     <= 1'b0;
            grant_q      <= '0;
            lorient_q    <= 2'b00;
            owner_q      <= '0;
            ov_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            orient_lat_q <= orient_lat_d;
            rr_last_q    <= rr_last_d;
            cnt_q        <= cnt_d;
            launch_q     <= launch_d;
            grant_q      <= grant_d;
            lorient_q    <= lorient_d;
            owner_q      <= owner_d;
            ov_q         <= ov_d;
        end
    end

    assign bus.launch        = launch_q;
    assign bus.grant         = grant_q;
    assign bus.launch_orient = lorient_q;
    assign bus.owner         = owner_q;
    assign bus.owner_valid   = ov_q;
    assign bus.pending       = pending_q;
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_bullet_fire_arbiter.sv
// Scoreboard bench for bullet_fire_arbiter (NUM_REQ=4, COOLDOWN_CNT=8, ACK_TIMEOUT=4).
// Launches are checked by a monitor against expectations queued at stimulus time.
module tb_bullet_fire_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic model_on;
    int   act_ctr = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    bullet_fire_arbiter_if #(.NUM_REQ(4)) ifc ();

    bullet_fire_arbiter #(
        .NUM_REQ(4),
        .COOLDOWN_CNT(8),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(ifc)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] ori;
        logic [1:0] own;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] o, input logic [1:0] w);
        exp_t e;
        e.grant = g;
        e.ori   = o;
        e.own   = w;
        sb.push_back(e);
    endtask

    // Bullet engine: busy from 2 cycles after launch, for 10 cycles
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            act_ctr = 0;
            ifc.bullet_act = 1'b0;
        end else if (act_ctr != 0) begin
            act_ctr++;
            if (act_ctr >= 12) begin
                act_ctr = 0;
                ifc.bullet_act = 1'b0;
            end else begin
                ifc.bullet_act = 1'b1;
            end
        end else if (ifc.launch && model_on) begin
            act_ctr = 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifc.launch) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_launch", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_grant", ifc.grant, e.grant);
                chk("sb_orient", ifc.launch_orient, e.ori);
                chk("sb_owner", ifc.owner, e.own);
                chk("sb_owner_valid", ifc.owner_valid, 1);
            end
        end
    end

    task automatic fire(input logic [3:0] m, input logic [7:0] o);
        ifc.fire_req  = m;
        ifc.orient_in = o;
        @(negedge clk);
        ifc.fire_req = '0;
    endtask

    task automatic wait_launch(output int n);
        n = 0;
        while (!ifc.launch && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("launch_seen", ifc.launch, 1);
    endtask

    task automatic wait_act(input logic lvl);
        int n = 0;
        while (ifc.bullet_act !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bullet_act_level", ifc.bullet_act, lvl);
    endtask

    task automatic wait_ov_low(output int n);
        n = 0;
        while (ifc.owner_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("owner_valid_low", ifc.owner_valid, 0);
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (ifc.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_low", ifc.busy, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ifc.busy || ifc.pending != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("idle", {ifc.busy, ifc.pending}, 0);
    endtask

    initial begin
        int n;
        int nl;
        rst_n = 1'b0;
        model_on = 1'b1;
        ifc.enable = 1'b1;
        ifc.fire_req = '0;
        ifc.orient_in = '0;
        #3;
        chk("rst_launch", ifc.launch, 0);
        chk("rst_grant", ifc.grant, 0);
        chk("rst_orient", ifc.launch_orient, 0);
        chk("rst_owner", ifc.owner, 0);
        chk("rst_ov", ifc.owner_valid, 0);
        chk("rst_pending", ifc.pending, 0);
        chk("rst_busy", ifc.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin from reset: 0,1,2,3
        fire(4'b1111, 8'b00_01_10_11);
        push(4'b0001, 2'b11, 2'd0);
        push(4'b0010, 2'b10, 2'd1);
        push(4'b0100, 2'b01, 2'd2);
        push(4'b1000, 2'b00, 2'd3);
        wait_idle();

        // Single fire timing
        fire(4'b0001, 8'b00_00_00_11);
        push(4'b0001, 2'b11, 2'd0);
        wait_launch(n);
        chk("t1_latency", n, 1);
        wait_act(1'b1);
        wait_act(1'b0);
        chk("t1_ov_at_act_fall", ifc.owner_valid, 1);
        @(negedge clk);
        chk("t1_ov_after", ifc.owner_valid, 0);
        wait_busy_low(n);
        chk("t1_cooldown", n, 8);
        chk("t1_owner_hold", ifc.owner, 0);

        // Launch timeout
        model_on = 1'b0;
        fire(4'b0010, 8'b00_00_10_00);
        push(4'b0010, 2'b10, 2'd1);
        wait_launch(n);
        wait_ov_low(n);
        chk("t3_timeout", n, 4);
        wait_busy_low(n);
        chk("t3_cooldown", n, 8);
        model_on = 1'b1;

        // Pause in cooldown with tank 2 pending
        wait_idle();
        fire(4'b1000, 8'b01_00_00_00);
        push(4'b1000, 2'b01, 2'd3);
        wait_launch(n);
        wait_act(1'b1);
        fire(4'b0100, 8'b00_00_00_00);
        push(4'b0100, 2'b00, 2'd2);
        wait_ov_low(n);
        repeat (3) @(negedge clk);
        ifc.enable = 1'b0;
        nl = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.launch) nl++;
        end
        chk("t4_no_grant", nl, 0);
        chk("t4_pending", ifc.pending, 4'b0100);
        chk("t4_busy", ifc.busy, 1);
        ifc.enable = 1'b1;
        wait_launch(n);
        chk("t4_resume", n, 6);

        // Repeat request on the grant edge
        wait_idle();
        ifc.fire_req = 4'b0100;
        ifc.orient_in = 8'b00_00_00_00;
        @(negedge clk);
        ifc.orient_in = 8'b00_11_00_00;
        push(4'b0100, 2'b00, 2'd2);
        push(4'b0100, 2'b11, 2'd2);
        @(negedge clk);
        ifc.fire_req = '0;
        chk("se_launch", ifc.launch, 1);
        chk("se_pending", ifc.pending, 4'b0100);

        // Asynchronous reset mid-flight
        wait_idle();
        fire(4'b0010, 8'b00_00_11_00);
        push(4'b0010, 2'b11, 2'd1);
        wait_launch(n);
        wait_act(1'b1);
        fire(4'b1000, 8'b11_00_00_00);
        chk("t5_in_flight", {ifc.busy, ifc.owner_valid}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_launch", ifc.launch, 0);
        chk("t5_grant", ifc.grant, 0);
        chk("t5_orient", ifc.launch_orient, 0);
        chk("t5_owner", ifc.owner, 0);
        chk("t5_ov", ifc.owner_valid, 0);
        chk("t5_pending", ifc.pending, 0);
        chk("t5_busy", ifc.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Player request arriving in cooldown behind pending AI tanks
        fire(4'b0001, 8'b00_00_00_11);
        push(4'b0001, 2'b11, 2'd0);
        wait_launch(n);
        wait_act(1'b1);
        fire(4'b1110, 8'b11_00_10_00);
        wait_ov_low(n);
        @(negedge clk);
        @(negedge clk);
        fire(4'b0001, 8'b00_00_00_01);
`ifdef FIRE_ARB_PLAYER_PRIO_EN
        push(4'b0001, 2'b01, 2'd0);
        push(4'b0010, 2'b10, 2'd1);
        push(4'b0100, 2'b00, 2'd2);
        push(4'b1000, 2'b11, 2'd3);
`else
        push(4'b0010, 2'b10, 2'd1);
        push(4'b0100, 2'b00, 2'd2);
        push(4'b1000, 2'b11, 2'd3);
        push(4'b0001, 2'b01, 2'd0);
`endif
        wait_idle();

        // Two simultaneous requests skip idle tanks
        fire(4'b1010, 8'b01_00_11_00);
        push(4'b0010, 2'b11, 2'd1);
        push(4'b1000, 2'b01, 2'd3);
        wait_idle();

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
